mux_nto1_rr: RTL and testbench

- Parametrised N-to-1 channel selector with a registered, handshaked output stage.
- Generalises the fixed 6-input 32-bit combinational selector in two ways:
  - width and channel count are parameters;
  - a round-robin arbitration mode is added beside explicit select.
- Sits between multiple producer units (e.g. functional-unit results) and a single consumer such as a writeback or bypass path.
- Each channel uses a valid/ready handshake, with a one-deep output register.

---
 rtl/mux_nto1_rr_pkg.sv | 19 +
 rtl/mux_nto1_rr_if.sv | 36 +++
 rtl/mux_nto1_rr_pick.sv | 32 +++
 rtl/mux_nto1_rr.sv | 97 +++++++++
 tb/tb_mux_nto1_rr.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mux_nto1_rr_pkg.sv
// Shared definitions for the N-to-1 round-robin channel selector.
//   mode_e    : MODE_SEL (explicit select) / MODE_RR (round-robin)
//   DefWidth  : default data width per channel
//   wrap_inc  : index increment that wraps at the channel count
package mux_nto1_rr_pkg;

  typedef enum logic {
    ModeSel = 1'b0,
    ModeRr  = 1'b1
  } mode_e;

  localparam int unsigned DefWidth = 32;

  // Next round-robin start position after granting channel g out of n channels.
  function automatic int unsigned wrap_inc(input int unsigned g, input int unsigned n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle between N producers, the selector and one consumer.
//   mode/sel            : selection control
//   in_data/in_valid    : producer words, channel i at [i*WIDTH +: WIDTH]
//   in_ready            : per-channel ready, at most one bit set
//   out_data/out_chan   : registered word and the channel it came from
//   out_valid/out_ready : consumer handshake
// master = the surrounding system, slave = the selector.
interface mux_nto1_rr_if
  import mux_nto1_rr_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N     = 6,
  parameter int unsigned SELW  = 3
) ();

  mode_e              mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/mux_nto1_rr_pick.sv
// Rotated priority encoder: finds the first asserted request scanning
// ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   req   : request vector
//   ptr   : scan start index (always < N)
//   found : some request is set
//   g     : index of the chosen request (0 when none)
module mux_nto1_rr_pick #(
  parameter int unsigned N    = 6,
  parameter int unsigned SELW = 3
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] g
);

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    g     = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 channel selector with a one-deep registered, handshaked output.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mux_nto1_rr_if slave (select control, producer and consumer sides)
// mode=MODE_SEL picks channel sel; mode=MODE_RR arbitrates round-robin
// starting at ptr. Throughput is one word per cycle with out_ready high.
module mux_nto1_rr
  import mux_nto1_rr_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N     = 6,
  parameter int unsigned SELW  = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  mux_nto1_rr_if.slave  bus
);

  localparam int unsigned NPad = 1 << SELW;

  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_chan_q;
  logic             out_valid_q;
  logic [SELW-1:0]  ptr_q;

  logic             load;
  logic             grant;
  logic             cand_found;
  logic [SELW-1:0]  cand;
  logic [WIDTH-1:0] cand_data;
  logic             rr_found;
  logic [SELW-1:0]  rr_g;
  logic [NPad-1:0]  valid_pad;

  mux_nto1_rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .found (rr_found),
    .g     (rr_g)
  );

  // Zero padding makes any sel >= N see an idle channel.
  assign valid_pad = NPad'(bus.in_valid);
  assign load      = !out_valid_q || bus.out_ready;

  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    if (bus.mode == ModeRr) begin
      cand       = rr_g;
      cand_found = rr_found;
    end else begin
      cand       = bus.sel;
      cand_found = valid_pad[bus.sel];
    end
  end

  assign grant = load && cand_found;

  always_comb begin
    cand_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand == SELW'(i)) cand_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Ready is gated by reset so no producer sees a transfer while in reset.
  assign bus.in_ready = (reset_n && grant) ? (N'(1) << cand) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      if (grant) begin
        out_data_q  <= cand_data;
        out_chan_q  <= cand;
        out_valid_q <= 1'b1;
      end else if (load) begin
        out_valid_q <= 1'b0;
      end
      if (grant && bus.mode == ModeRr) begin
        ptr_q <= SELW'(wrap_inc(32'(cand), N));
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
module tb_mux_nto1_rr;
  import mux_nto1_rr_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 6;
  localparam int unsigned SELW  = 3;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  chan;
  } exp_t;

  logic clock;
  logic reset_n;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  mux_nto1_rr_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

  mux_nto1_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_word(input int unsigned ch, input logic [WIDTH-1:0] d);
    exp_t e;
    e.data = d;
    e.chan = SELW'(ch);
    exp_q.push_back(e);
  endtask

  // Monitor: a word is consumed when valid && ready are seen mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h/%0d expected none", bus.out_data, bus.out_chan);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 64'(bus.out_data), 64'(e.data));
        check("sb_chan", 64'(bus.out_chan), 64'(e.chan));
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    bus.mode      = ModeSel;
    bus.sel       = 3'd3;
    bus.in_valid  = 6'b111111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = 32'h100 + i;
    #1;
    check("ready_in_reset", 64'(bus.in_ready), 64'h0);
    check("valid_in_reset", 64'(bus.out_valid), 64'h0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;

    // Explicit select of channel 3
    check("sel3_ready", 64'(bus.in_ready), 64'b001000);
    expect_word(3, 32'h103);
    tick();
    check("sel3_valid", 64'(bus.out_valid), 64'h1);
    check("sel3_data", 64'(bus.out_data), 64'h103);
    // Out-of-range select
    bus.sel = 3'd7;
    #1;
    check("sel7_ready", 64'(bus.in_ready), 64'h0);
    tick();
    check("sel7_valid_drop", 64'(bus.out_valid), 64'h0);
    check("sel_ptr_hold", 64'(dut.ptr_q), 64'h0);

    // Round-robin rotation, all channels valid
    bus.mode = ModeRr;
    for (int k = 0; k < 8; k++) begin
      expect_word(k % N, 32'h100 + (k % N));
      tick();
      check("rr_valid", 64'(bus.out_valid), 64'h1);
      check("rr_chan", 64'(bus.out_chan), 64'(k % N));
    end

    // Bring ptr to 5 with a lone grant on channel 4
    bus.in_valid = 6'b010000;
    expect_word(4, 32'h104);
    tick();
    check("ptr_at5", 64'(dut.ptr_q), 64'd5);

    // Wrap: from ptr 5, requests {1,2} -> 1, 2, 1
    bus.in_valid = 6'b000110;
    #1;
    check("wrap_ready", 64'(bus.in_ready), 64'b000010);
    expect_word(1, 32'h101);
    tick();
    expect_word(2, 32'h102);
    tick();
    check("wrap_chan2", 64'(bus.out_chan), 64'd2);
    expect_word(1, 32'h101);
    tick();
    check("wrap_chan1", 64'(bus.out_chan), 64'd1);
    check("wrap_ptr", 64'(dut.ptr_q), 64'd2);

    // Drain, then backpressure
    bus.in_valid = '0;
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'h0);
    bus.in_valid  = 6'b111111;
    bus.out_ready = 1'b0;
    expect_word(2, 32'h102);
    tick();
    check("bp_load_chan", 64'(bus.out_chan), 64'd2);
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 64'(bus.in_ready), 64'h0);
      tick();
      check("bp_data", 64'(bus.out_data), 64'h102);
      check("bp_valid", 64'(bus.out_valid), 64'h1);
      check("bp_ptr", 64'(dut.ptr_q), 64'd3);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'b001000);
    expect_word(3, 32'h103);
    tick();
    check("bp_release_chan", 64'(bus.out_chan), 64'd3);

    // Mode switch: grant 2 in rr, two explicit grants of 0, back to rr -> 3
    bus.in_valid = 6'b000100;
    expect_word(2, 32'h102);
    tick();
    bus.mode     = ModeSel;
    bus.sel      = 3'd0;
    bus.in_valid = 6'b111111;
    expect_word(0, 32'h100);
    tick();
    expect_word(0, 32'h100);
    tick();
    check("msw_ptr_hold", 64'(dut.ptr_q), 64'd3);
    bus.mode = ModeRr;
    #1;
    check("msw_ready", 64'(bus.in_ready), 64'b001000);
    expect_word(3, 32'h103);
    tick();
    check("msw_chan", 64'(bus.out_chan), 64'd3);
    bus.in_valid = '0;
    tick();

    // Asynchronous reset while holding a word
    bus.in_data[5*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    bus.mode      = ModeSel;
    bus.sel       = 3'd5;
    bus.in_valid  = 6'b100000;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = '0;
    check("pre_rst_data", 64'(bus.out_data), 64'hDEAD_BEEF);
    check("pre_rst_ptr", 64'(dut.ptr_q), 64'd4);
    #2;
    reset_n      = 1'b0;
    bus.in_valid = 6'b111111;
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'h0);
    check("rst_data", 64'(bus.out_data), 64'h0);
    check("rst_chan", 64'(bus.out_chan), 64'h0);
    check("rst_ptr", 64'(dut.ptr_q), 64'h0);
    check("rst_ready", 64'(bus.in_ready), 64'h0);
    tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
